// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit
// Description : Multi-cycle load/store controller in front of a word-addressed,
//               word-write-only data memory. It takes one request at a time,
//               forms the effective address and checks alignment and range.
//               Loads are extracted and sign/zero extended. Sub-word stores
//               are done as read-modify-write.
// Ports       : clk, rst                  - clock, sync active-high reset
//               req_*                     - request from execute (valid/ready)
//               mem_we/addr/wdata/rdata   - data memory port (combinational read)
//               resp_*                    - completion pulse plus writeback info
// Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit #(
  parameter int ADDR_W = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_base,
  input  logic [15:0] req_offset,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic [4:0]  resp_rd,
  output logic        resp_wen,
  output logic        resp_fault
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_READ  = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_RESP  = 3'd4;

  logic [2:0]        r_state;
  logic [1:0]        r_size;
  logic              r_unsigned;
  logic [ADDR_W+1:0] r_ea;       // only the in-range part of the address is kept
  logic [31:0]       r_wdata;
  logic [4:0]        r_rd;
  logic [31:0]       r_merge;
  logic [31:0]       r_resp_data;
  logic [4:0]        r_resp_rd;
  logic              r_resp_wen;
  logic              r_resp_fault;

  logic [31:0] w_ea;
  logic        w_fault;
  logic        w_accept;
  logic [4:0]  w_shamt;
  logic [31:0] w_lane_data;
  logic [31:0] w_load_ext;
  logic [31:0] w_lane_mask;
  logic [31:0] w_ins_data;
  logic [31:0] w_merge;
  logic        w_mem_active;

  assign w_ea = req_base + {{16{req_offset[15]}}, req_offset};

  assign w_fault = (w_ea[31:ADDR_W+2] != '0)
                 || ((req_size == 2'b01) && w_ea[0])
                 || (req_size[1] && (w_ea[1:0] != 2'b00));

  assign w_accept = req_valid && (r_state == S_IDLE);

  // Byte-lane shift; words are always aligned so their shift is zero.
  assign w_shamt     = {r_ea[1:0], 3'b000};
  assign w_lane_data = mem_rdata >> w_shamt;

  always_comb begin
    w_load_ext = w_lane_data;
    case (r_size)
      2'b00:   w_load_ext = {{24{~r_unsigned & w_lane_data[7]}},  w_lane_data[7:0]};
      2'b01:   w_load_ext = {{16{~r_unsigned & w_lane_data[15]}}, w_lane_data[15:0]};
      default: w_load_ext = w_lane_data;
    endcase
  end

  assign w_lane_mask = ((r_size == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF) << w_shamt;
  assign w_ins_data  = r_wdata << w_shamt;
  assign w_merge     = (mem_rdata & ~w_lane_mask) | (w_ins_data & w_lane_mask);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_size       <= 2'b00;
      r_unsigned   <= 1'b0;
      r_ea         <= '0;
      r_wdata      <= 32'd0;
      r_rd         <= 5'd0;
      r_merge      <= 32'd0;
      r_resp_data  <= 32'd0;
      r_resp_rd    <= 5'd0;
      r_resp_wen   <= 1'b0;
      r_resp_fault <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_size     <= req_size;
            r_unsigned <= req_unsigned;
            r_ea       <= w_ea[ADDR_W+1:0];
            r_wdata    <= req_wdata;
            r_rd       <= req_rd;
            if (w_fault) begin
              // Response fields change only on entry to RESP so they hold
              // steady between pulses.
              r_resp_data  <= 32'd0;
              r_resp_rd    <= req_rd;
              r_resp_wen   <= 1'b0;
              r_resp_fault <= 1'b1;
              r_state      <= S_RESP;
            end else if (!req_store) begin
              r_state <= S_LOAD;
            end else if (req_size[1]) begin
              r_state <= S_WRITE;
            end else begin
              r_state <= S_READ;
            end
          end
        end
        S_LOAD: begin
          r_resp_data  <= w_load_ext;
          r_resp_rd    <= r_rd;
          r_resp_wen   <= 1'b1;
          r_resp_fault <= 1'b0;
          r_state      <= S_RESP;
        end
        S_READ: begin
          r_merge <= w_merge;
          r_state <= S_WRITE;
        end
        S_WRITE: begin
          r_resp_data  <= 32'd0;
          r_resp_rd    <= r_rd;
          r_resp_wen   <= 1'b0;
          r_resp_fault <= 1'b0;
          r_state      <= S_RESP;
        end
        S_RESP: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign w_mem_active = (r_state == S_LOAD) || (r_state == S_READ) || (r_state == S_WRITE);

  assign req_ready  = (r_state == S_IDLE);
  assign mem_we     = (r_state == S_WRITE);
  assign mem_addr   = w_mem_active ? {{(32-ADDR_W){1'b0}}, r_ea[ADDR_W+1:2]} : 32'd0;
  assign mem_wdata  = (r_state == S_WRITE) ? (r_size[1] ? r_wdata : r_merge) : 32'd0;
  assign resp_valid = (r_state == S_RESP);
  assign resp_data  = r_resp_data;
  assign resp_rd    = r_resp_rd;
  assign resp_wen   = r_resp_wen;
  assign resp_fault = r_resp_fault;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_load_store_unit
// Description : Self-checking bench for load_store_unit. A byte-level
//               reference memory predicts every response and memory write,
//               and a per-cycle compare process checks them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_base;
  logic [15:0] req_offset;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic [4:0]  resp_rd;
  logic        resp_wen;
  logic        resp_fault;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_W(5)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_base(req_base),
    .req_offset(req_offset), .req_wdata(req_wdata), .req_rd(req_rd),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_rd(resp_rd),
    .resp_wen(resp_wen), .resp_fault(resp_fault)
  );

  function automatic logic [31:0] init_word(int i);
    if (i == 3) return 32'h8899_AABB;
    return (32'(i) * 32'h0101_0101) ^ 32'h5A5A_5A5A;
  endfunction

  // Memory the DUT talks to.
  logic [31:0] mem [0:31];
  logic        preload = 1'b1;
  assign mem_rdata = mem[mem_addr[4:0]];
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 32; i++) mem[i] <= init_word(i);
    end else if (mem_we) begin
      mem[mem_addr[4:0]] <= mem_wdata;
    end
  end

  // Reference model state and expectation queues.
  logic [31:0] ref_mem [0:31];
  typedef struct { int cyc; logic [31:0] data; logic [4:0] rd; logic wen; logic fault; } resp_t;
  typedef struct { int cyc; logic [4:0] addr; logic [31:0] data; } wr_t;
  resp_t rq[$];
  wr_t   wq[$];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  bit run = 1'b0;

  logic [31:0] last_resp_data;
  logic [4:0]  last_resp_rd;
  logic        last_resp_fault;
  logic        last_resp_wen;
  logic [31:0] last_wr_data;
  logic [31:0] last_addr;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: effective address, fault, and byte-by-byte load/store on ref_mem.
  task automatic model_push(input bit st, input logic [1:0] sz, input bit un,
                            input logic [31:0] base, input logic [15:0] off,
                            input logic [31:0] wd, input logic [4:0] rd, input int acc);
    logic [31:0] ea;
    logic [31:0] val;
    logic [31:0] w;
    int nb;
    int idx;
    int lane;
    bit flt;
    ea   = base + {{16{off[15]}}, off};
    nb   = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    idx  = int'(ea[6:2]);
    lane = int'(ea[1:0]);
    flt  = (ea[31:7] != 0) || (nb == 2 && ea[0]) || (nb == 4 && ea[1:0] != 0);
    if (flt) begin
      rq.push_back('{acc, 32'd0, rd, 1'b0, 1'b1});
    end else if (!st) begin
      val = 32'd0;
      for (int i = 0; i < nb; i++) val[8*i +: 8] = ref_mem[idx][8*(lane+i) +: 8];
      if (!un && nb < 4 && val[8*nb-1])
        for (int i = 8*nb; i < 32; i++) val[i] = 1'b1;
      rq.push_back('{acc + 1, val, rd, 1'b1, 1'b0});
    end else begin
      w = ref_mem[idx];
      for (int i = 0; i < nb; i++) w[8*(lane+i) +: 8] = wd[8*i +: 8];
      ref_mem[idx] = w;
      if (nb == 4) begin
        wq.push_back('{acc, 5'(idx), w});
        rq.push_back('{acc + 1, 32'd0, rd, 1'b0, 1'b0});
      end else begin
        wq.push_back('{acc + 1, 5'(idx), w});
        rq.push_back('{acc + 2, 32'd0, rd, 1'b0, 1'b0});
      end
    end
  endtask

  // Per-cycle comparison against the expectation queues.
  always @(negedge clk) begin : cmp
    resp_t e;
    wr_t   w;
    if (run) begin
      if (resp_valid) begin
        if (rq.size() == 0) begin
          chk32("resp_valid_unexpected", {31'd0, resp_valid}, 32'd0);
        end else begin
          e = rq.pop_front();
          chk32("resp_cycle", 32'(cyc), 32'(e.cyc));
          chk32("resp_data", resp_data, e.data);
          chk32("resp_rd", {27'd0, resp_rd}, {27'd0, e.rd});
          chk32("resp_wen", {31'd0, resp_wen}, {31'd0, e.wen});
          chk32("resp_fault", {31'd0, resp_fault}, {31'd0, e.fault});
        end
        last_resp_data  = resp_data;
        last_resp_rd    = resp_rd;
        last_resp_fault = resp_fault;
        last_resp_wen   = resp_wen;
      end else if (rq.size() > 0 && rq[0].cyc <= cyc) begin
        chk32("resp_valid_missing", {31'd0, resp_valid}, 32'd1);
        void'(rq.pop_front());
      end
      if (mem_we) begin
        if (wq.size() == 0) begin
          chk32("mem_we_unexpected", {31'd0, mem_we}, 32'd0);
        end else begin
          w = wq.pop_front();
          chk32("write_cycle", 32'(cyc), 32'(w.cyc));
          chk32("write_addr", mem_addr, {27'd0, w.addr});
          chk32("write_data", mem_wdata, w.data);
        end
        last_wr_data = mem_wdata;
      end else if (wq.size() > 0 && wq[0].cyc <= cyc) begin
        chk32("mem_we_missing", {31'd0, mem_we}, 32'd1);
        void'(wq.pop_front());
      end
      if (req_ready) chk32("idle_mem_bus", mem_addr | mem_wdata, 32'd0);
    end
  end

  // Drive a request (caller is at a negedge); waits for ready, returns after the accept edge.
  task automatic issue(input bit st, input logic [1:0] sz, input bit un,
                       input logic [31:0] base, input logic [15:0] off,
                       input logic [31:0] wd, input logic [4:0] rd,
                       input bit use_model, output int acc);
    int n;
    n = 0;
    req_valid = 1'b1; req_store = st; req_size = sz; req_unsigned = un;
    req_base = base; req_offset = off; req_wdata = wd; req_rd = rd;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      checks++; failures++;
      $display("FAIL accept_timeout: req_ready never rose (t=%0t)", $time);
    end
    acc = cyc + 1;
    if (use_model) model_push(st, sz, un, base, off, wd, rd, acc);
    @(posedge clk);
  endtask

  task automatic drain();
    int n;
    n = 0;
    do begin
      @(negedge clk); #1;
      n++;
    end while (!(req_ready && rq.size() == 0 && wq.size() == 0) && n < 30);
    if (!(req_ready && rq.size() == 0 && wq.size() == 0)) begin
      checks++; failures++;
      $display("FAIL drain_timeout: got ready=%0b pending=%0d expected idle", req_ready, rq.size() + wq.size());
      rq.delete(); wq.delete();
    end
  endtask

  task automatic single(input bit st, input logic [1:0] sz, input bit un,
                        input logic [31:0] base, input logic [15:0] off,
                        input logic [31:0] wd, input logic [4:0] rd);
    int acc;
    @(negedge clk);
    issue(st, sz, un, base, off, wd, rd, 1'b1, acc);
    @(negedge clk);
    req_valid = 1'b0;
    last_addr = mem_addr;
    drain();
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int a1, a2, a3, acc;
    for (int i = 0; i < 32; i++) ref_mem[i] = init_word(i);
    rst = 1'b1; req_valid = 1'b0; req_store = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_base = 32'd0; req_offset = 16'd0; req_wdata = 32'd0; req_rd = 5'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    preload = 1'b0;
    chk32("reset_ready", {31'd0, req_ready}, 32'd1);
    chk32("reset_outputs", {29'd0, resp_valid, mem_we, resp_wen}, 32'd0);
    chk32("reset_resp_data", resp_data | mem_addr | mem_wdata, 32'd0);
    chk32("reset_resp_misc", {26'd0, resp_rd, resp_fault}, 32'd0);
    rst = 1'b0;
    run = 1'b1;

    // LB / LBU from word 3 byte 1
    single(1'b0, 2'b00, 1'b0, 32'h0C, 16'h0001, 32'd0, 5'd7);
    chk32("lb_data", last_resp_data, 32'hFFFF_FFAA);
    chk32("lb_rd", {27'd0, last_resp_rd}, 32'd7);
    single(1'b0, 2'b00, 1'b1, 32'h0C, 16'h0001, 32'd0, 5'd8);
    chk32("lbu_data", last_resp_data, 32'h0000_00AA);
    // LW with negative offset
    single(1'b0, 2'b10, 1'b0, 32'h10, 16'hFFFC, 32'd0, 5'd9);
    chk32("lw_data", last_resp_data, 32'h8899_AABB);
    chk32("lw_addr", last_addr, 32'd3);
    // SB then LW
    single(1'b1, 2'b00, 1'b0, 32'h0E, 16'h0000, 32'h11, 5'd2);
    chk32("sb_merge", last_wr_data, 32'h8811_AABB);
    chk32("sb_wen", {31'd0, last_resp_wen}, 32'd0);
    single(1'b0, 2'b10, 1'b0, 32'h0C, 16'h0000, 32'd0, 5'd4);
    chk32("lw_after_sb", last_resp_data, 32'h8811_AABB);
    // Faults: misaligned half, out-of-range word
    single(1'b0, 2'b01, 1'b0, 32'h0D, 16'h0000, 32'd0, 5'd5);
    chk32("lh_mis_fault", {31'd0, last_resp_fault}, 32'd1);
    single(1'b0, 2'b10, 1'b0, 32'h80, 16'h0000, 32'd0, 5'd6);
    chk32("lw_oor_fault", {31'd0, last_resp_fault}, 32'd1);
    chk32("lw_oor_data", last_resp_data, 32'd0);

    // SH aborted by reset in READ: no write, no response
    @(negedge clk);
    issue(1'b1, 2'b01, 1'b0, 32'h0C, 16'h0002, 32'hCAFE, 5'd10, 1'b0, acc);
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk32("ready_after_reset", {31'd0, req_ready}, 32'd1);
    single(1'b0, 2'b10, 1'b0, 32'h0C, 16'h0000, 32'd0, 5'd11);
    chk32("word3_unchanged", last_resp_data, 32'h8811_AABB);

    // Three LWs with req_valid held high
    @(negedge clk);
    issue(1'b0, 2'b10, 1'b0, 32'h00, 16'h0000, 32'd0, 5'd1, 1'b1, a1);
    @(negedge clk);
    issue(1'b0, 2'b10, 1'b0, 32'h04, 16'h0000, 32'd0, 5'd2, 1'b1, a2);
    @(negedge clk);
    issue(1'b0, 2'b10, 1'b0, 32'h08, 16'h0000, 32'd0, 5'd3, 1'b1, a3);
    @(negedge clk);
    req_valid = 1'b0;
    drain();
    chk32("b2b_gap1", 32'(a2 - a1), 32'd3);
    chk32("b2b_gap2", 32'(a3 - a2), 32'd3);
    chk32("b2b_last_rd", {27'd0, last_resp_rd}, 32'd3);

    // Half store / signed and unsigned half loads
    single(1'b1, 2'b01, 1'b0, 32'h10, 16'h0002, 32'h1234_BEEF, 5'd12);
    single(1'b0, 2'b01, 1'b0, 32'h12, 16'h0000, 32'd0, 5'd13);
    chk32("lh_signed", last_resp_data, 32'hFFFF_BEEF);
    single(1'b0, 2'b01, 1'b1, 32'h12, 16'h0000, 32'd0, 5'd14);
    chk32("lhu", last_resp_data, 32'h0000_BEEF);
    // Top word boundary, size 11 treated as word
    single(1'b1, 2'b10, 1'b0, 32'h7C, 16'h0000, 32'h1234_5678, 5'd15);
    chk32("sw_data", last_wr_data, 32'h1234_5678);
    single(1'b0, 2'b11, 1'b0, 32'h7C, 16'h0000, 32'd0, 5'd16);
    chk32("lw_size3", last_resp_data, 32'h1234_5678);
    single(1'b0, 2'b00, 1'b0, 32'h7F, 16'h0000, 32'd0, 5'd17);
    chk32("lb_top_byte", last_resp_data, 32'h0000_0012);
    single(1'b1, 2'b10, 1'b0, 32'h7E, 16'h0000, 32'hDEAD_BEEF, 5'd18);
    chk32("sw_mis_fault", {31'd0, last_resp_fault}, 32'd1);
    single(1'b0, 2'b00, 1'b0, 32'h0, 16'hFFFF, 32'd0, 5'd19);
    chk32("lb_neg_fault", {31'd0, last_resp_fault}, 32'd1);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
